// File: rtl/nor_bus_pkg.sv
// Shared types and defaults for the wired-NOR bus scheduler.
// Holds the FSM state encoding and the per-bit timing helper.
package nor_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StPre,
    StEval,
    StSamp,
    StDone
  } state_e;

  localparam int unsigned DefN       = 4;
  localparam int unsigned DefW       = 8;
  localparam int unsigned DefEvalCyc = 2;

  // Cycles spent per transferred bit: precharge + evaluate + sample.
  function automatic int unsigned bit_period(input int unsigned eval_cyc);
    return 2 + eval_cyc;
  endfunction

endpackage

// File: rtl/nor_rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or above pointer, with wrap.
module nor_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] pointer,
  input  logic            enable,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] index,
  output logic            valid
);

  int unsigned     cand;
  logic [IdxW-1:0] cidx;

  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (int'(pointer) + k) % N;
      cidx = IdxW'(cand);
      if (enable && !valid && req[cidx]) begin
        valid       = 1'b1;
        grant[cidx] = 1'b1;
        index       = cidx;
      end
    end
  end

endmodule

// File: rtl/nor_bus_scheduler.sv
// Arbitrates N requesters onto a wired-NOR line and serialises the winner's word
// through precharge / evaluate / sample phases, MSB first.
module nor_bus_scheduler
  import nor_bus_pkg::*;
#(
  parameter int unsigned N        = DefN,
  parameter int unsigned W        = DefW,
  parameter int unsigned EVAL_CYC = DefEvalCyc
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   gate,
  output logic           pchg,
  input  logic           bus_in,
  output logic           done,
  output logic [W-1:0]   rx_word,
  output logic           err
);

  localparam int unsigned PtrW = $clog2(N);
  localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q;
  logic [PtrW-1:0] ptr_q;
  logic [W-1:0]    tx_q, rx_q, rx_word_q;
  logic [IdxW-1:0] idx_q;
  logic [3:0]      ev_q;
  logic            err_q;

  logic [N-1:0]    arb_gnt;
  logic [PtrW-1:0] arb_idx;
  logic            arb_valid;
  logic            cur_bit, samp_bit;
  logic [W-1:0]    rx_next;

  nor_rr_arbiter #(
    .N    (N),
    .IdxW (PtrW)
  ) u_arb (
    .req     (req),
    .pointer (ptr_q),
    .enable  (state_q == StArb),
    .grant   (arb_gnt),
    .index   (arb_idx),
    .valid   (arb_valid)
  );

  assign cur_bit  = tx_q[W-1];
  // A pulled-low line reads back as a 1 bit.
  assign samp_bit = ~bus_in;
  assign rx_next  = (rx_q << 1) | W'(samp_bit);

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|req) state_d = StArb;
      StArb:   state_d = arb_valid ? StPre : StIdle;
      StPre:   state_d = StEval;
      StEval:  if (ev_q == '0) state_d = StSamp;
      StSamp:  state_d = (idx_q == '0) ? StDone : StPre;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      ptr_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_word_q <= '0;
      idx_q     <= '0;
      ev_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StArb: begin
          if (arb_valid) begin
            gnt_q <= arb_gnt;
            tx_q  <= req_data[arb_idx*W +: W];
            idx_q <= IdxW'(W - 1);
            err_q <= 1'b0;
            ptr_q <= (arb_idx == PtrW'(N - 1)) ? '0 : arb_idx + PtrW'(1);
          end
        end
        StPre:  ev_q <= 4'(EVAL_CYC - 1);
        StEval: if (ev_q != '0) ev_q <= ev_q - 4'd1;
        StSamp: begin
          rx_q <= rx_next;
          tx_q <= tx_q << 1;
          if (bus_in != ~cur_bit) err_q <= 1'b1;
          if (idx_q == '0) rx_word_q <= rx_next;
          else             idx_q     <= idx_q - IdxW'(1);
        end
        StDone:  gnt_q <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    gate = '0;
    pchg = 1'b1;
    ack  = '0;
    done = 1'b0;
    unique case (state_q)
      StEval, StSamp: begin
        pchg = 1'b0;
        gate = cur_bit ? gnt_q : '0;
      end
      StDone: begin
        done = 1'b1;
        ack  = gnt_q;
      end
      default: ;
    endcase
  end

  assign gnt     = gnt_q;
  assign rx_word = rx_word_q;
  assign err     = err_q;

endmodule

// File: tb/tb_nor_bus_scheduler.sv
// Directed bench for nor_bus_scheduler with a wired-NOR line model and protocol monitor.
module tb_nor_bus_scheduler;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
  localparam int unsigned E = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   ack, gnt, gate;
  logic           pchg, bus_in, done, err;
  logic [W-1:0]   rx_word;
  logic           stuck_low = 1'b0;

  int checks = 0;
  int errors = 0;

  nor_bus_scheduler #(
    .N        (N),
    .W        (W),
    .EVAL_CYC (E)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .gnt      (gnt),
    .gate     (gate),
    .pchg     (pchg),
    .bus_in   (bus_in),
    .done     (done),
    .rx_word  (rx_word),
    .err      (err)
  );

  // Pulled-up line, any active pull-down drags it low.
  assign bus_in = stuck_low ? 1'b0 : ~|gate;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (!$onehot0(gate)) begin
        errors++;
        $display("FAIL onehot_gate: gate=%b required at most one bit set", gate);
      end
      checks++;
      if (pchg && |gate) begin
        errors++;
        $display("FAIL pchg_gate_overlap: pchg=%b gate=%b required not both", pchg, gate);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one transaction from IDLE; corrupts req_data after ARB to prove it is latched.
  task automatic run_one(input int who, input logic [W-1:0] data, output int lat,
                         output logic [W-1:0] gseq, output logic [W-1:0] rxw,
                         output logic e, output logic [N-1:0] a);
    logic prev_p;
    int   nb;
    @(negedge clk);
    req_data[who*W +: W] = data;
    req    = N'(1) << who;
    lat    = -1;
    gseq   = '0;
    rxw    = '0;
    e      = 1'b0;
    a      = '0;
    nb     = 0;
    prev_p = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 3) req_data[who*W +: W] = ~data;
      if (prev_p && !pchg && nb < W) begin
        gseq = (gseq << 1) | W'(gate[who]);
        nb++;
      end
      prev_p = pchg;
      if (done) begin
        lat = k;
        rxw = rx_word;
        e   = err;
        a   = ack;
        req = '0;
        break;
      end
    end
    req = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pchg !== 1'b1 || gate !== '0 || gnt !== '0 || ack !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: pchg=%b gate=%b gnt=%b ack=%b done=%b required 1/0/0/0/0",
               pchg, gate, gnt, ack, done);
    end
    checks++;
    if (rx_word !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: rx_word=%h err=%b required 00/0", rx_word, err);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle;
    int pulses;
    pulses = 0;
    req = '0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL idle_done: %0d done pulses required 0", pulses);
    end
    checks++;
    if (pchg !== 1'b1 || gate !== '0 || gnt !== '0) begin
      errors++;
      $display("FAIL idle_ctrl: pchg=%b gate=%b gnt=%b required 1/0/0", pchg, gate, gnt);
    end
  endtask

  task automatic test_single;
    int lat;
    logic [W-1:0] gseq, rxw;
    logic e;
    logic [N-1:0] a;
    run_one(1, 8'hA5, lat, gseq, rxw, e, a);
    checks++;
    if (lat != 34) begin
      errors++;
      $display("FAIL single_latency: %0d cycles required 34", lat);
    end
    checks++;
    if (rxw !== 8'hA5 || e !== 1'b0) begin
      errors++;
      $display("FAIL single_rx: rx_word=%h err=%b required a5/0", rxw, e);
    end
    checks++;
    if (a !== 4'b0010) begin
      errors++;
      $display("FAIL single_ack: ack=%b required 0010", a);
    end
    checks++;
    if (gseq !== 8'hA5) begin
      errors++;
      $display("FAIL single_gate_seq: gate[1] bits=%b required 10100101", gseq);
    end
  endtask

  task automatic test_stuck;
    int lat;
    logic [W-1:0] gseq, rxw;
    logic e;
    logic [N-1:0] a;
    stuck_low = 1'b1;
    run_one(3, 8'hFF, lat, gseq, rxw, e, a);
    checks++;
    if (lat != 34 || rxw !== 8'hFF || e !== 1'b0) begin
      errors++;
      $display("FAIL stuck_ff: lat=%0d rx_word=%h err=%b required 34/ff/0", lat, rxw, e);
    end
    run_one(3, 8'h80, lat, gseq, rxw, e, a);
    checks++;
    if (lat != 34 || rxw !== 8'hFF || e !== 1'b1) begin
      errors++;
      $display("FAIL stuck_80: lat=%0d rx_word=%h err=%b required 34/ff/1", lat, rxw, e);
    end
    stuck_low = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit seen;
    @(negedge clk);
    req_data[2*W +: W] = 8'h5A;
    req = 4'b0100;
    // Cycle 19 after the request is the first EVAL cycle of bit 3.
    repeat (19) @(negedge clk);
    checks++;
    if (pchg !== 1'b0 || gnt !== 4'b0100) begin
      errors++;
      $display("FAIL mid_in_eval: pchg=%b gnt=%b required 0/0100", pchg, gnt);
    end
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    checks++;
    if (gate !== '0 || pchg !== 1'b1 || gnt !== '0 || done !== 1'b0 || ack !== '0) begin
      errors++;
      $display("FAIL mid_abort: gate=%b pchg=%b gnt=%b done=%b ack=%b required 0/1/0/0/0",
               gate, pchg, gnt, done, ack);
    end
    rst = 1'b0;
    @(negedge clk);
    req_data[0 +: W] = 8'h3C;
    req = 4'b1111;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL mid_restart_ptr: gnt=%b required 0001", gnt);
    end
    req  = 4'b0001;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || ack !== 4'b0001 || rx_word !== 8'h3C) begin
      errors++;
      $display("FAIL mid_rerun: done=%b ack=%b rx_word=%h required 1/0001/3c",
               seen, ack, rx_word);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] d [N];
    int last, nd, exp_i;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      d[i] = 8'h0F * (i + 1);
      req_data[i*W +: W] = d[i];
    end
    @(negedge clk);
    req  = 4'b1111;
    last = 0;
    nd   = 0;
    for (int k = 1; k <= 300 && nd < 5; k++) begin
      @(negedge clk);
      if (done) begin
        exp_i = nd % N;
        checks++;
        if (ack !== (N'(1) << exp_i) || rx_word !== d[exp_i]) begin
          errors++;
          $display("FAIL b2b_txn%0d: ack=%b rx_word=%h required %b/%h",
                   nd, ack, rx_word, N'(1) << exp_i, d[exp_i]);
        end
        checks++;
        if (k - last != ((nd == 0) ? 34 : 35)) begin
          errors++;
          $display("FAIL b2b_gap%0d: %0d cycles required %0d", nd, k - last,
                   (nd == 0) ? 34 : 35);
        end
        last = k;
        nd++;
      end
    end
    req = '0;
    checks++;
    if (nd != 5) begin
      errors++;
      $display("FAIL b2b_count: %0d transactions required 5", nd);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_stuck();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
